// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the OpenMIPS pipeline controller: stall vectors, exception codes, FSM states.
package pipe_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Stall vector bits: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
    localparam logic [5:0] STALL_NONE  = {6{NO_STOP}};
    localparam logic [5:0] STALL_IF_ID = {{3{NO_STOP}}, {3{STOP}}};
    localparam logic [5:0] STALL_EX    = {{2{NO_STOP}}, {4{STOP}}};
    localparam logic [5:0] STALL_MEM   = {NO_STOP, {5{STOP}}};
    localparam logic [5:0] STALL_ALL   = {6{STOP}};

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INV     = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    typedef enum logic {
        StRun,
        StFlush
    } pipe_state_e;

    // Redirect target for a nonzero exception code.
    function automatic logic [31:0] exc_target(input logic [31:0] excepttype,
                                               input logic [31:0] epc,
                                               input logic [31:0] vec_int,
                                               input logic [31:0] vec_gen);
        logic [31:0] target;
        unique case (excepttype)
            EXC_INT:  target = vec_int;
            EXC_ERET: target = epc;
            default:  target = vec_gen;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, exception freeze/flush, stall counters.
// Optional consecutive-stall watchdog enabled by the PIPE_CTRL_TIMEOUT_EN macro.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned  FLUSH_CYCLES  = 1,
    parameter int unsigned  STALL_TIMEOUT = 1024,
    parameter logic [31:0]  EXC_VEC_INT   = 32'h0000_0020,
    parameter logic [31:0]  EXC_VEC_GEN   = 32'h0000_0040
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stallreq_if,
    input  logic        i_stallreq_id,
    input  logic        i_stallreq_ex,
    input  logic        i_stallreq_mem,
    input  logic [31:0] i_excepttype,
    input  logic [31:0] i_cp0_epc,
    output logic [5:0]  o_stall,
    output logic        o_flush,
    output logic [31:0] o_new_pc,
    output logic [31:0] o_stall_cnt,
    output logic        o_stall_timeout
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || STALL_TIMEOUT > 65535) begin : gen_bad_cfg
        $error("pipe_ctrl: FLUSH_CYCLES must be 1..15 and STALL_TIMEOUT must fit 16 bits");
    end

    localparam logic [3:0] FCNT_LAST = 4'(FLUSH_CYCLES - 1);

    pipe_state_e state;
    logic [3:0]  fcnt;
    logic        exc_valid;

    assign exc_valid = (i_excepttype != 32'h0);

    // Exception outranks every stall request; nothing stalls while flushing or in reset.
    always_comb begin
        o_stall = STALL_NONE;
        if (!i_rst && state == StRun) begin
            if (exc_valid) begin
                o_stall = STALL_ALL;
            end else begin
                casez ({i_stallreq_mem, i_stallreq_ex, i_stallreq_id, i_stallreq_if})
                    4'b1???: o_stall = STALL_MEM;
                    4'b01??: o_stall = STALL_EX;
                    4'b001?: o_stall = STALL_IF_ID;
                    4'b0001: o_stall = STALL_IF_ID;
                    default: o_stall = STALL_NONE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= StRun;
            fcnt        <= 4'd0;
            o_flush     <= 1'b0;
            o_new_pc    <= 32'h0;
            o_stall_cnt <= 32'h0;
        end else begin
            if (o_stall != STALL_NONE && o_stall_cnt != 32'hFFFF_FFFF) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
            case (state)
                StRun: begin
                    if (exc_valid) begin
                        state    <= StFlush;
                        fcnt     <= 4'd0;
                        o_flush  <= 1'b1;
                        o_new_pc <= exc_target(i_excepttype, i_cp0_epc, EXC_VEC_INT, EXC_VEC_GEN);
                    end
                end
                StFlush: begin
                    fcnt <= fcnt + 4'd1;
                    if (fcnt == FCNT_LAST) begin
                        o_flush <= 1'b0;
                        state   <= StRun;
                    end
                end
                default: state <= StRun;
            endcase
        end
    end

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(STALL_TIMEOUT);

    logic [15:0] run_stall_cnt;
    logic        timeout_flag;
    logic        stall_run;

    // The freeze cycle enters FLUSH, so it clears rather than counts.
    assign stall_run = (o_stall != STALL_NONE) && !(state == StRun && exc_valid);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run_stall_cnt <= 16'h0;
            timeout_flag  <= 1'b0;
        end else if (stall_run) begin
            if (run_stall_cnt != 16'hFFFF) begin
                run_stall_cnt <= run_stall_cnt + 16'd1;
            end
            if ({1'b0, run_stall_cnt} + 17'd1 >= TIMEOUT_LIMIT) begin
                timeout_flag <= 1'b1;
            end
        end else begin
            run_stall_cnt <= 16'h0;
        end
    end

    assign o_stall_timeout = timeout_flag;
`else
    assign o_stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: default instance plus a FLUSH_CYCLES=3/STALL_TIMEOUT=8 one.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam logic EXP_TO = 1'b1;
`else
    localparam logic EXP_TO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sif, sid, sex, smem;
    logic [31:0] exc, epc;

    logic [5:0]  a_stall, b_stall;
    logic        a_flush, b_flush;
    logic [31:0] a_new_pc, b_new_pc;
    logic [31:0] a_stall_cnt, b_stall_cnt;
    logic        a_timeout, b_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut_a (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stallreq_if   (sif),
        .i_stallreq_id   (sid),
        .i_stallreq_ex   (sex),
        .i_stallreq_mem  (smem),
        .i_excepttype    (exc),
        .i_cp0_epc       (epc),
        .o_stall         (a_stall),
        .o_flush         (a_flush),
        .o_new_pc        (a_new_pc),
        .o_stall_cnt     (a_stall_cnt),
        .o_stall_timeout (a_timeout)
    );

    pipe_ctrl #(
        .FLUSH_CYCLES  (3),
        .STALL_TIMEOUT (8)
    ) dut_b (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stallreq_if   (sif),
        .i_stallreq_id   (sid),
        .i_stallreq_ex   (sex),
        .i_stallreq_mem  (smem),
        .i_excepttype    (exc),
        .i_cp0_epc       (epc),
        .o_stall         (b_stall),
        .o_flush         (b_flush),
        .o_new_pc        (b_new_pc),
        .o_stall_cnt     (b_stall_cnt),
        .o_stall_timeout (b_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        {smem, sex, sid, sif} = 4'b0000;
        exc = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        tick();
        rst = 1'b0;
    endtask

    // {mem, ex, id, if} request patterns and the stall vector each must produce.
    logic [3:0] req_tab [6] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0110, 4'b1001};
    logic [5:0] exp_tab [6] = '{6'h1F, 6'h0F, 6'h07, 6'h07, 6'h0F, 6'h1F};

    initial begin
        int exp_cnt;
        clear_in();
        epc  = 32'h0;
        rst  = 1'b1;
        smem = 1'b1;
        tick();
        #1;
        check("stall_in_reset", {26'b0, a_stall}, 32'h0);
        tick();
        check("rst_flush", {31'b0, a_flush}, 32'h0);
        check("rst_new_pc", a_new_pc, 32'h0);
        check("rst_stall_cnt", a_stall_cnt, 32'h0);
        check("rst_timeout", {31'b0, a_timeout}, 32'h0);
        rst  = 1'b0;
        smem = 1'b0;

        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            {smem, sex, sid, sif} = req_tab[i];
            #1;
            check("stall_vec", {26'b0, a_stall}, {26'b0, exp_tab[i]});
            tick();
            exp_cnt++;
            check("stall_cnt", a_stall_cnt, exp_cnt);
        end
        clear_in();
        #1;
        check("stall_none", {26'b0, a_stall}, 32'h0);
        tick();
        check("stall_cnt_idle", a_stall_cnt, exp_cnt);

        // Syscall with a concurrent mem wait.
        exc  = 32'h8;
        smem = 1'b1;
        #1;
        check("freeze_vec", {26'b0, a_stall}, 32'h3F);
        tick();
        exp_cnt++;
        check("exc_flush", {31'b0, a_flush}, 32'h1);
        check("exc_new_pc", a_new_pc, 32'h40);
        check("flush_stall", {26'b0, a_stall}, 32'h0);
        check("freeze_counted", a_stall_cnt, exp_cnt);
        clear_in();
        tick();
        check("post_flush", {31'b0, a_flush}, 32'h0);
        check("post_stall", {26'b0, a_stall}, 32'h0);
        check("new_pc_hold", a_new_pc, 32'h40);

        do_reset();
        exc = 32'he;
        epc = 32'h0000_1234;
        tick();
        check("eret_flush", {31'b0, a_flush}, 32'h1);
        check("eret_pc", a_new_pc, 32'h1234);
        exc = 32'h0;
        tick();
        exc = 32'h1;
        tick();
        check("int_pc", a_new_pc, 32'h20);
        exc = 32'h0;
        tick();

        // Three-cycle flush with the exception held throughout.
        do_reset();
        exc  = 32'h8;
        smem = 1'b1;
        #1;
        check("b_freeze", {26'b0, b_stall}, 32'h3F);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("b_flush_on", {31'b0, b_flush}, 32'h1);
            check("b_flush_stall", {26'b0, b_stall}, 32'h0);
        end
        tick();
        check("b_flush_off", {31'b0, b_flush}, 32'h0);
        check("b_redetect", {26'b0, b_stall}, 32'h3F);
        check("b_single_freeze", b_stall_cnt, 32'h1);
        tick();
        check("b_flush_again", {31'b0, b_flush}, 32'h1);
        rst = 1'b1;
        clear_in();
        tick();
        rst = 1'b0;
        check("rst_abort_flush", {31'b0, b_flush}, 32'h0);
        check("rst_abort_cnt", b_stall_cnt, 32'h0);
        check("rst_abort_pc", b_new_pc, 32'h0);

        sex = 1'b1;
        repeat (7) tick();
        check("timeout_early", {31'b0, b_timeout}, 32'h0);
        tick();
        check("timeout_set", {31'b0, b_timeout}, {31'b0, EXP_TO});
        sex = 1'b0;
        tick();
        tick();
        check("timeout_sticky", {31'b0, b_timeout}, {31'b0, EXP_TO});
        check("a_no_timeout", {31'b0, a_timeout}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
